// File: rtl/hazard3_riscv_timer_mc.sv
`default_nettype none
// ============================================================================
// Module      : hazard3_riscv_timer_mc
// Description : APB machine timer. It has a 64-bit mtime with a prescaled
//               tick timebase and N_HARTS mtimecmp comparators. Each
//               comparator drives one registered per-hart level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard3_riscv_timer_mc #(
  parameter int N_HARTS     = 2,
  parameter int TICK_IS_NRZ = 0,
  parameter int PRESCALE_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        paddr,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr,
  input  logic               dbg_halt,
  input  logic               tick,
  output logic [N_HARTS-1:0] timer_irq
);

  // --------------------------------------------------------------------------
  // Register state
  // --------------------------------------------------------------------------
  logic                  en;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] pcount;
  logic [63:0]           mtime;
  logic [63:0]           mtimecmp [N_HARTS];

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic        wr_en;
  logic        rd_en;
  logic        hit_ctrl;
  logic        hit_pre;
  logic        hit_mtl;
  logic        hit_mth;
  logic [15:0] cmp_off;
  logic [12:0] cmp_idx;
  logic        cmp_hit;
  logic        mapped;
  logic [N_HARTS-1:0] cmp_lo_sel;
  logic [N_HARTS-1:0] cmp_hi_sel;

  assign wr_en    = psel & penable & pwrite;
  assign rd_en    = psel & penable & ~pwrite;
  assign hit_ctrl = (paddr == 16'h0000);
  assign hit_pre  = (paddr == 16'h0004);
  assign hit_mtl  = (paddr == 16'h0008);
  assign hit_mth  = (paddr == 16'h000C);

  // Comparator slots start at 0x10 and take 8 bytes each: low word, then high word
  assign cmp_off  = paddr - 16'h0010;
  assign cmp_idx  = cmp_off[15:3];
  assign cmp_hit  = (paddr >= 16'h0010) && (cmp_off[1:0] == 2'b00) &&
                    (cmp_idx < 13'(N_HARTS));
  assign mapped   = hit_ctrl | hit_pre | hit_mtl | hit_mth | cmp_hit;

  generate
    for (genvar i = 0; i < N_HARTS; i++) begin : g_cmp_sel
      assign cmp_lo_sel[i] = cmp_hit && (cmp_idx == 13'(i)) && !cmp_off[2];
      assign cmp_hi_sel[i] = cmp_hit && (cmp_idx == 13'(i)) &&  cmp_off[2];
    end
  endgenerate

  assign pready  = 1'b1;
  assign pslverr = psel & penable & ~mapped;

  // Read mux; an unmapped address decodes to no source and returns zero
  logic [31:0] rdata;
  always_comb begin
    rdata = 32'h0;
    if (hit_ctrl) rdata = {31'h0, en};
    if (hit_pre)  rdata = 32'(prescale);
    if (hit_mtl)  rdata = mtime[31:0];
    if (hit_mth)  rdata = mtime[63:32];
    for (int i = 0; i < N_HARTS; i++) begin
      if (cmp_lo_sel[i]) rdata = rdata | mtimecmp[i][31:0];
      if (cmp_hi_sel[i]) rdata = rdata | mtimecmp[i][63:32];
    end
  end

  assign prdata = rd_en ? rdata : 32'h0;

  // --------------------------------------------------------------------------
  // Tick timebase
  // --------------------------------------------------------------------------
  logic tick_event;
  logic tick_now;

  generate
    if (TICK_IS_NRZ != 0) begin : g_nrz
      logic sync1;
      logic sync2;
      logic prev;
      // Synchronise the async toggle and detect either edge on it
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1 <= 1'b0;
          sync2 <= 1'b0;
          prev  <= 1'b0;
        end else begin
          sync1 <= tick;
          sync2 <= sync1;
          prev  <= sync2;
        end
      end
      assign tick_event = sync2 ^ prev;
    end else begin : g_lvl
      assign tick_event = tick;
    end
  endgenerate

  assign tick_now = tick_event & en & ~dbg_halt;

  // --------------------------------------------------------------------------
  // mtime next-state. A bus write replaces one half. The other half keeps the
  // incremented value, so a carry out of the low word still reaches the high word.
  // --------------------------------------------------------------------------
  logic        pc_wrap;
  logic        mtime_step;
  logic [63:0] mtime_next;

  assign pc_wrap    = (pcount == prescale);
  assign mtime_step = tick_now & pc_wrap;

  always_comb begin
    mtime_next = mtime_step ? (mtime + 64'd1) : mtime;
    if (wr_en && hit_mtl) mtime_next[31:0]  = pwdata;
    if (wr_en && hit_mth) mtime_next[63:32] = pwdata;
  end

  // Control registers, prescaler counter and mtime
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en       <= 1'b1;
      prescale <= '0;
      pcount   <= '0;
      mtime    <= 64'h0;
    end else begin
      if (wr_en && hit_ctrl) en <= pwdata[0];
      if (wr_en && hit_pre) begin
        prescale <= pwdata[PRESCALE_W-1:0];
        pcount   <= '0;
      end else if (tick_now) begin
        pcount   <= pc_wrap ? '0 : pcount + PRESCALE_W'(1);
      end
      mtime <= mtime_next;
    end
  end

  // Comparator registers, loaded one 32-bit half at a time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_HARTS; i++) mtimecmp[i] <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      for (int i = 0; i < N_HARTS; i++) begin
        if (wr_en && cmp_lo_sel[i]) mtimecmp[i][31:0]  <= pwdata;
        if (wr_en && cmp_hi_sel[i]) mtimecmp[i][63:32] <= pwdata;
      end
    end
  end

  // Per-hart interrupt, registered from the currently visible register values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_irq <= '0;
    end else begin
      for (int i = 0; i < N_HARTS; i++) timer_irq[i] <= (mtime >= mtimecmp[i]);
    end
  end

endmodule
`default_nettype wire
